// File: rtl/reg_file_flags_if.sv
// Bus bundle between the register file/flag block and its driver (ALU datapath or bench).
// master drives addresses, write data and flag inputs; slave returns read data and flags.
interface reg_file_flags_if #(
    parameter int W = 8,
    parameter int A = 3
);
    logic [A-1:0] RaddrA;
    logic [A-1:0] RaddrB;
    logic [A-1:0] Waddr;
    logic         WriteEn;
    logic [W-1:0] DataIn;
    logic         FlagWrEn;
    logic         CarryIn;
    logic         ZeroIn;
    logic         CarryClr;
    logic [W-1:0] DataOutA;
    logic [W-1:0] DataOutB;
    logic         CarryOut;
    logic         ZeroOut;
    logic [7:0]   WrCount;

    modport master (
        output RaddrA, RaddrB, Waddr, WriteEn, DataIn,
        output FlagWrEn, CarryIn, ZeroIn, CarryClr,
        input  DataOutA, DataOutB, CarryOut, ZeroOut, WrCount
    );

    modport slave (
        input  RaddrA, RaddrB, Waddr, WriteEn, DataIn,
        input  FlagWrEn, CarryIn, ZeroIn, CarryClr,
        output DataOutA, DataOutB, CarryOut, ZeroOut, WrCount
    );
endinterface

// File: rtl/reg_file_flags.sv
// Register file with carry/zero flags and a saturating write counter around the ALU.
// Optional macro REG_FILE_BYPASS_EN adds write-to-read forwarding for data and carry.
module reg_file_flags #(
    parameter int W = 8,
    parameter int A = 3
) (
    input  logic                CLK,
    input  logic                Reset,
    reg_file_flags_if.slave     bus
);
    localparam int DEPTH = 2 ** A;

    logic [W-1:0] regs_q [DEPTH];
    logic [W-1:0] regs_d [DEPTH];
    logic         carry_q, carry_d;
    logic         zero_q, zero_d;
    logic [7:0]   wr_count_q, wr_count_d;

    always_comb begin
        regs_d     = regs_q;
        carry_d    = carry_q;
        zero_d     = zero_q;
        wr_count_d = wr_count_q;
        if (bus.WriteEn) begin
            regs_d[bus.Waddr] = bus.DataIn;
            if (wr_count_q != 8'hFF) begin
                wr_count_d = wr_count_q + 8'd1;
            end
        end
        if (bus.FlagWrEn) begin
            carry_d = bus.CarryIn;
            zero_d  = bus.ZeroIn;
        end
        // Clear wins for the carry only; zero still follows FlagWrEn.
        if (bus.CarryClr) begin
            carry_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
            wr_count_q <= 8'h00;
        end else begin
            regs_q     <= regs_d;
            carry_q    <= carry_d;
            zero_q     <= zero_d;
            wr_count_q <= wr_count_d;
        end
    end

`ifdef REG_FILE_BYPASS_EN
    assign bus.DataOutA = (bus.WriteEn && (bus.RaddrA == bus.Waddr)) ? bus.DataIn
                                                                     : regs_q[bus.RaddrA];
    assign bus.DataOutB = (bus.WriteEn && (bus.RaddrB == bus.Waddr)) ? bus.DataIn
                                                                     : regs_q[bus.RaddrB];
    assign bus.CarryOut = (bus.FlagWrEn && !bus.CarryClr) ? bus.CarryIn : carry_q;
`else
    assign bus.DataOutA = regs_q[bus.RaddrA];
    assign bus.DataOutB = regs_q[bus.RaddrB];
    assign bus.CarryOut = carry_q;
`endif
    assign bus.ZeroOut = zero_q;
    assign bus.WrCount = wr_count_q;
endmodule

// File: tb/tb_reg_file_flags.sv
// Directed bench for reg_file_flags: reset, writes, same-cycle read, flags, 16-bit add, counter.
module tb_reg_file_flags;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    reg_file_flags_if #(.W(8), .A(3)) bus ();

    reg_file_flags #(.W(8), .A(3)) dut (
        .CLK   (clk),
        .Reset (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic idle();
        bus.WriteEn  = 1'b0;
        bus.FlagWrEn = 1'b0;
        bus.CarryClr = 1'b0;
        bus.CarryIn  = 1'b0;
        bus.ZeroIn   = 1'b0;
        bus.DataIn   = 8'h00;
        bus.Waddr    = 3'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [2:0] addr, input logic [7:0] data);
        bus.WriteEn = 1'b1;
        bus.Waddr   = addr;
        bus.DataIn  = data;
        tick();
        idle();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        write_reg(3'd1, 8'h11);
        write_reg(3'd6, 8'h66);
        write_reg(3'd7, 8'hC3);
        bus.FlagWrEn = 1'b1; bus.CarryIn = 1'b1; bus.ZeroIn = 1'b1;
        tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.RaddrA = 3'(i);
            bus.RaddrB = 3'(7 - i);
            #1;
            checks++;
            if (bus.DataOutA !== 8'h00 || bus.DataOutB !== 8'h00) begin
                errors++;
                $display("FAIL reset_regs i=%0d got A=%h B=%h want 00 00", i, bus.DataOutA, bus.DataOutB);
            end
        end
        checks++;
        if (bus.CarryOut !== 1'b0 || bus.ZeroOut !== 1'b0 || bus.WrCount !== 8'h00) begin
            errors++;
            $display("FAIL reset_flags got C=%b Z=%b cnt=%h want 0 0 00", bus.CarryOut, bus.ZeroOut, bus.WrCount);
        end
    endtask

    task automatic test_write_read();
        write_reg(3'd3, 8'hA5);
        write_reg(3'd5, 8'h3C);
        bus.RaddrA = 3'd3;
        bus.RaddrB = 3'd5;
        #1;
        checks++;
        if (bus.DataOutA !== 8'hA5 || bus.DataOutB !== 8'h3C) begin
            errors++;
            $display("FAIL write_read got A=%h B=%h want a5 3c", bus.DataOutA, bus.DataOutB);
        end
        checks++;
        if (bus.WrCount !== 8'h02) begin
            errors++;
            $display("FAIL write_count got %h want 02", bus.WrCount);
        end
        bus.RaddrA = 3'd5;
        bus.RaddrB = 3'd5;
        #1;
        checks++;
        if (bus.DataOutA !== 8'h3C || bus.DataOutB !== 8'h3C) begin
            errors++;
            $display("FAIL same_reg_both_ports got A=%h B=%h want 3c 3c", bus.DataOutA, bus.DataOutB);
        end
    endtask

    task automatic test_same_cycle();
        logic [7:0] exp_now;
`ifdef REG_FILE_BYPASS_EN
        exp_now = 8'h7F;
`else
        exp_now = 8'h00;
`endif
        bus.WriteEn = 1'b1;
        bus.Waddr   = 3'd2;
        bus.DataIn  = 8'h7F;
        bus.RaddrA  = 3'd2;
        bus.RaddrB  = 3'd3;
        #1;
        checks++;
        if (bus.DataOutA !== exp_now || bus.DataOutB !== 8'hA5) begin
            errors++;
            $display("FAIL same_cycle_read got A=%h B=%h want %h a5", bus.DataOutA, bus.DataOutB, exp_now);
        end
        tick();
        idle();
        checks++;
        if (bus.DataOutA !== 8'h7F) begin
            errors++;
            $display("FAIL next_cycle_read got %h want 7f", bus.DataOutA);
        end
    endtask

    task automatic test_flags();
        bus.FlagWrEn = 1'b1; bus.CarryIn = 1'b1; bus.ZeroIn = 1'b1;
        tick();
        idle();
        checks++;
        if (bus.CarryOut !== 1'b1 || bus.ZeroOut !== 1'b1) begin
            errors++;
            $display("FAIL flag_set got C=%b Z=%b want 1 1", bus.CarryOut, bus.ZeroOut);
        end
        bus.CarryIn = 1'b0; bus.ZeroIn = 1'b0;
        tick();
        checks++;
        if (bus.CarryOut !== 1'b1 || bus.ZeroOut !== 1'b1) begin
            errors++;
            $display("FAIL flag_hold got C=%b Z=%b want 1 1", bus.CarryOut, bus.ZeroOut);
        end
        bus.CarryClr = 1'b1; bus.FlagWrEn = 1'b1; bus.CarryIn = 1'b1; bus.ZeroIn = 1'b0;
        tick();
        idle();
        checks++;
        if (bus.CarryOut !== 1'b0 || bus.ZeroOut !== 1'b0) begin
            errors++;
            $display("FAIL clr_priority got C=%b Z=%b want 0 0", bus.CarryOut, bus.ZeroOut);
        end
        bus.FlagWrEn = 1'b1; bus.CarryIn = 1'b1; bus.ZeroIn = 1'b1;
        tick();
        idle();
        bus.CarryClr = 1'b1;
        tick();
        idle();
        checks++;
        if (bus.CarryOut !== 1'b0 || bus.ZeroOut !== 1'b1) begin
            errors++;
            $display("FAIL clr_only got C=%b Z=%b want 0 1", bus.CarryOut, bus.ZeroOut);
        end
    endtask

    task automatic test_add16();
        write_reg(3'd2, 8'hFF);
        write_reg(3'd3, 8'h01);
        write_reg(3'd4, 8'h01);
        write_reg(3'd5, 8'h00);
        bus.CarryClr = 1'b1;
        tick();
        idle();
        // LSW: FF + 01 + 0 = 00, carry 1
        bus.RaddrA = 3'd2; bus.RaddrB = 3'd3;
        #1;
        checks++;
        if (bus.DataOutA !== 8'hFF || bus.DataOutB !== 8'h01 || bus.CarryOut !== 1'b0) begin
            errors++;
            $display("FAIL add_lsw_operands got A=%h B=%h C=%b want ff 01 0", bus.DataOutA, bus.DataOutB, bus.CarryOut);
        end
        bus.WriteEn = 1'b1; bus.Waddr = 3'd0; bus.DataIn = 8'h00;
        bus.FlagWrEn = 1'b1; bus.CarryIn = 1'b1; bus.ZeroIn = 1'b1;
        tick();
        idle();
        bus.RaddrA = 3'd0; bus.RaddrB = 3'd4;
        #1;
        checks++;
        if (bus.DataOutA !== 8'h00 || bus.CarryOut !== 1'b1 || bus.DataOutB !== 8'h01) begin
            errors++;
            $display("FAIL add_lsw_result got r0=%h C=%b r4=%h want 00 1 01", bus.DataOutA, bus.CarryOut, bus.DataOutB);
        end
        // MSW: 01 + 00 + 1 = 02, carry 0
        bus.RaddrA = 3'd4; bus.RaddrB = 3'd5;
        bus.WriteEn = 1'b1; bus.Waddr = 3'd1; bus.DataIn = 8'h02;
        bus.FlagWrEn = 1'b1; bus.CarryIn = 1'b0; bus.ZeroIn = 1'b0;
        tick();
        idle();
        bus.RaddrA = 3'd1; bus.RaddrB = 3'd0;
        #1;
        checks++;
        if (bus.DataOutA !== 8'h02 || bus.DataOutB !== 8'h00 || bus.CarryOut !== 1'b0 || bus.ZeroOut !== 1'b0) begin
            errors++;
            $display("FAIL add_msw_result got r1=%h r0=%h C=%b Z=%b want 02 00 0 0",
                     bus.DataOutA, bus.DataOutB, bus.CarryOut, bus.ZeroOut);
        end
    endtask

    task automatic test_back_to_back();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 260; i++) begin
            bus.WriteEn = 1'b1;
            bus.Waddr   = 3'(i % 8);
            bus.DataIn  = 8'(i);
            tick();
            if (i == 9) begin
                checks++;
                if (bus.WrCount !== 8'h0A) begin
                    errors++;
                    $display("FAIL count_10 got %h want 0a", bus.WrCount);
                end
            end
            if (i == 253) begin
                checks++;
                if (bus.WrCount !== 8'hFE) begin
                    errors++;
                    $display("FAIL count_254 got %h want fe", bus.WrCount);
                end
            end
            if (i == 254) begin
                checks++;
                if (bus.WrCount !== 8'hFF) begin
                    errors++;
                    $display("FAIL count_255 got %h want ff", bus.WrCount);
                end
            end
        end
        idle();
        bus.RaddrA = 3'd3;
        bus.RaddrB = 3'd4;
        #1;
        checks++;
        if (bus.WrCount !== 8'hFF) begin
            errors++;
            $display("FAIL count_saturate got %h want ff", bus.WrCount);
        end
        checks++;
        if (bus.DataOutA !== 8'h03 || bus.DataOutB !== 8'hFC) begin
            errors++;
            $display("FAIL last_writes got r3=%h r4=%h want 03 fc", bus.DataOutA, bus.DataOutB);
        end
        bus.FlagWrEn = 1'b1; bus.CarryIn = 1'b1; bus.ZeroIn = 1'b1;
        tick();
        idle();
        rst = 1'b1;
        bus.WriteEn = 1'b1; bus.Waddr = 3'd6; bus.DataIn = 8'hEE;
        bus.FlagWrEn = 1'b1; bus.CarryIn = 1'b1; bus.ZeroIn = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        bus.RaddrA = 3'd6;
        #1;
        checks++;
        if (bus.DataOutA !== 8'h00 || bus.WrCount !== 8'h00) begin
            errors++;
            $display("FAIL reset_wins_write got r6=%h cnt=%h want 00 00", bus.DataOutA, bus.WrCount);
        end
        checks++;
        if (bus.CarryOut !== 1'b0 || bus.ZeroOut !== 1'b0) begin
            errors++;
            $display("FAIL reset_wins_flags got C=%b Z=%b want 0 0", bus.CarryOut, bus.ZeroOut);
        end
    endtask

    initial begin
        idle();
        bus.RaddrA = 3'd0;
        bus.RaddrB = 3'd0;
        rst = 1'b1;
        tick();
        tick();
        test_reset();
        test_write_read();
        test_same_cycle();
        test_flags();
        test_add16();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
